// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite widths, types and response codes
package axi_lite_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0]   addr_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [DATA_WIDTH/8-1:0] strb_t;
  typedef logic [1:0]              resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite signal bundle with master/slave views
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2:1 round-robin pick
// The requester that did not complete last is preferred.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);
  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i[~last_i]) gnt_idx_o = ~last_i;
    else                gnt_idx_o = last_i;
  end
endmodule

// File: rtl/axi_lite_arb2.sv
// rtl/axi_lite_arb2.sv - two-master AXI4-Lite arbiter, one transaction in flight
// Out-of-window requests are answered locally with DECERR and never reach m.
module axi_lite_arb2
  import axi_lite_pkg::*;
#(
  parameter addr_t BASE_ADDR = 32'h0000_0000,
  parameter addr_t WIN_BYTES = 32'h0000_2000
) (
  input  logic        aclk,
  input  logic        areset_n,
  axi_lite_if.slave   s0,
  axi_lite_if.slave   s1,
  axi_lite_if.master  m,
  output logic        grant_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_ERR_R, ST_ERR_B
  } state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] ph_q, ph_d;

  logic [1:0] req;
  logic       win_valid, win_idx, w_rd, w_in_win;
  addr_t      w_addr;

  assign req = {s1.arvalid | s1.awvalid, s0.arvalid | s0.awvalid};

  rr_arb2 u_rr (
    .req_i       (req),
    .last_i      (last_q),
    .gnt_valid_o (win_valid),
    .gnt_idx_o   (win_idx)
  );

  assign w_rd     = win_idx ? s1.arvalid : s0.arvalid;
  assign w_addr   = w_rd ? (win_idx ? s1.araddr : s0.araddr)
                         : (win_idx ? s1.awaddr : s0.awaddr);
  assign w_in_win = (w_addr - BASE_ADDR) < WIN_BYTES;

  // Request side of the granted master
  addr_t g_araddr, g_awaddr;
  data_t g_wdata;
  strb_t g_wstrb;
  logic  g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;

  assign g_araddr  = grant_q ? s1.araddr  : s0.araddr;
  assign g_arvalid = grant_q ? s1.arvalid : s0.arvalid;
  assign g_awaddr  = grant_q ? s1.awaddr  : s0.awaddr;
  assign g_awvalid = grant_q ? s1.awvalid : s0.awvalid;
  assign g_wdata   = grant_q ? s1.wdata   : s0.wdata;
  assign g_wstrb   = grant_q ? s1.wstrb   : s0.wstrb;
  assign g_wvalid  = grant_q ? s1.wvalid  : s0.wvalid;
  assign g_rready  = grant_q ? s1.rready  : s0.rready;
  assign g_bready  = grant_q ? s1.bready  : s0.bready;

  logic  r_arready, r_awready, r_wready, r_rvalid, r_bvalid;
  data_t r_rdata;
  resp_t r_rresp, r_bresp;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ph_d      = ph_q;
    m.araddr  = '0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awaddr  = '0;
    m.awvalid = 1'b0;
    m.wdata   = '0;
    m.wstrb   = '0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    r_arready = 1'b0;
    r_awready = 1'b0;
    r_wready  = 1'b0;
    r_rvalid  = 1'b0;
    r_bvalid  = 1'b0;
    r_rdata   = '0;
    r_rresp   = RESP_OKAY;
    r_bresp   = RESP_OKAY;
    case (state_q)
      ST_IDLE: begin
        ph_d = 2'd0;
        if (win_valid) begin
          grant_d = win_idx;
          if (w_rd) state_d = w_in_win ? ST_AR : ST_ERR_R;
          else      state_d = w_in_win ? ST_AW : ST_ERR_B;
        end
      end
      ST_AR: begin
        m.araddr  = g_araddr;
        m.arvalid = g_arvalid;
        r_arready = m.arready;
        if (g_arvalid && m.arready) state_d = ST_R;
      end
      ST_R: begin
        m.rready = g_rready;
        r_rvalid = m.rvalid;
        r_rdata  = m.rdata;
        r_rresp  = m.rresp;
        if (m.rvalid && g_rready) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      ST_AW: begin
        m.awaddr  = g_awaddr;
        m.awvalid = g_awvalid;
        r_awready = m.awready;
        if (g_awvalid && m.awready) state_d = ST_W;
      end
      ST_W: begin
        m.wdata  = g_wdata;
        m.wstrb  = g_wstrb;
        m.wvalid = g_wvalid;
        r_wready = m.wready;
        if (g_wvalid && m.wready) state_d = ST_B;
      end
      ST_B: begin
        m.bready = g_bready;
        r_bvalid = m.bvalid;
        r_bresp  = m.bresp;
        if (m.bvalid && g_bready) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      ST_ERR_R: begin
        // ph 0: one-cycle address accept, ph 1: DECERR response
        if (ph_q == 2'd0) begin
          r_arready = 1'b1;
          ph_d      = 2'd1;
        end else begin
          r_rvalid = 1'b1;
          r_rresp  = RESP_DECERR;
          if (g_rready) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR_B: begin
        if (ph_q == 2'd0) begin
          r_awready = 1'b1;
          ph_d      = 2'd1;
        end else if (ph_q == 2'd1) begin
          r_wready = g_wvalid;
          if (g_wvalid) ph_d = 2'd2;
        end else begin
          r_bvalid = 1'b1;
          r_bresp  = RESP_DECERR;
          if (g_bready) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ph_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ph_q    <= ph_d;
    end
  end

  // Only the granted master sees responses; the other stalls on zeros
  logic sel0, sel1;
  assign sel0 = ~grant_q;
  assign sel1 = grant_q;

  assign s0.arready = sel0 & r_arready;
  assign s0.awready = sel0 & r_awready;
  assign s0.wready  = sel0 & r_wready;
  assign s0.rvalid  = sel0 & r_rvalid;
  assign s0.bvalid  = sel0 & r_bvalid;
  assign s0.rdata   = sel0 ? r_rdata : '0;
  assign s0.rresp   = sel0 ? r_rresp : RESP_OKAY;
  assign s0.bresp   = sel0 ? r_bresp : RESP_OKAY;

  assign s1.arready = sel1 & r_arready;
  assign s1.awready = sel1 & r_awready;
  assign s1.wready  = sel1 & r_wready;
  assign s1.rvalid  = sel1 & r_rvalid;
  assign s1.bvalid  = sel1 & r_bvalid;
  assign s1.rdata   = sel1 ? r_rdata : '0;
  assign s1.rresp   = sel1 ? r_rresp : RESP_OKAY;
  assign s1.bresp   = sel1 ? r_bresp : RESP_OKAY;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb/tb_axi_lite_arb2.sv - self-checking bench for axi_lite_arb2
module tb_axi_lite_arb2;
  import axi_lite_pkg::*;

  localparam addr_t TB_BASE = 32'h0000_0000;
  localparam addr_t TB_WIN  = 32'h0000_2000;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic grant_o, busy_o;
  always #5 aclk = ~aclk;

  axi_lite_if s0_if ();
  axi_lite_if s1_if ();
  axi_lite_if m_if ();

  axi_lite_arb2 #(.BASE_ADDR(TB_BASE), .WIN_BYTES(TB_WIN)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .s0       (s0_if),
    .s1       (s1_if),
    .m        (m_if),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory slave on m, plus the bench's own expectation of memory contents
  logic [31:0] mem [0:2047];
  logic [31:0] model_mem [0:2047];
  int          wr_count = 0;
  logic        have_aw = 1'b0;
  addr_t       aw_addr_q;
  addr_t       rd_addr [2];
  addr_t       wr_addr [2];
  int          glog [$];
  logic        m_quiet = 1'b0;

  function automatic logic in_win(input addr_t a);
    return (a - TB_BASE) < TB_WIN;
  endfunction

  initial begin
    m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
    m_if.rvalid = 1'b0; m_if.bvalid = 1'b0;
    m_if.rdata = '0; m_if.rresp = RESP_OKAY; m_if.bresp = RESP_OKAY;
    forever begin
      logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rst;
      addr_t ra, wa; data_t wd; strb_t ws;
      @(posedge aclk);
      ar_hs = m_if.arvalid & m_if.arready; ra = m_if.araddr;
      r_hs  = m_if.rvalid & m_if.rready;
      aw_hs = m_if.awvalid & m_if.awready; wa = m_if.awaddr;
      w_hs  = m_if.wvalid & m_if.wready; wd = m_if.wdata; ws = m_if.wstrb;
      b_hs  = m_if.bvalid & m_if.bready;
      rst   = !areset_n;
      #1;
      if (rst) begin
        m_if.rvalid = 1'b0; m_if.bvalid = 1'b0; have_aw = 1'b0;
      end else begin
        if (r_hs) m_if.rvalid = 1'b0;
        if (ar_hs) begin
          m_if.rvalid = 1'b1; m_if.rdata = mem[ra[12:2]]; m_if.rresp = RESP_OKAY;
        end
        if (b_hs) m_if.bvalid = 1'b0;
        if (aw_hs) begin have_aw = 1'b1; aw_addr_q = wa; end
        if (w_hs) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[aw_addr_q[12:2]][8*b +: 8] = wd[8*b +: 8];
          wr_count++;
          have_aw = 1'b0;
          m_if.bvalid = 1'b1; m_if.bresp = RESP_OKAY;
        end
      end
    end
  end

  // Per-port accessors
  function automatic logic sig(input int p, input int k);
    case (k)
      0: return p ? s1_if.arready : s0_if.arready;
      1: return p ? s1_if.rvalid  : s0_if.rvalid;
      2: return p ? s1_if.awready : s0_if.awready;
      3: return p ? s1_if.wready  : s0_if.wready;
      default: return p ? s1_if.bvalid : s0_if.bvalid;
    endcase
  endfunction
  function automatic data_t rdata_p(input int p);
    return p ? s1_if.rdata : s0_if.rdata;
  endfunction
  function automatic resp_t rresp_p(input int p);
    return p ? s1_if.rresp : s0_if.rresp;
  endfunction
  function automatic resp_t bresp_p(input int p);
    return p ? s1_if.bresp : s0_if.bresp;
  endfunction
  function automatic logic rready_p(input int p);
    return p ? s1_if.rready : s0_if.rready;
  endfunction
  function automatic logic bready_p(input int p);
    return p ? s1_if.bready : s0_if.bready;
  endfunction
  function automatic logic [31:0] ctl_p(input int p);
    if (p != 0)
      return {23'b0, s1_if.arready, s1_if.awready, s1_if.wready, s1_if.rvalid,
              s1_if.bvalid, s1_if.rresp, s1_if.bresp};
    return {23'b0, s0_if.arready, s0_if.awready, s0_if.wready, s0_if.rvalid,
            s0_if.bvalid, s0_if.rresp, s0_if.bresp};
  endfunction

  task automatic drv_ar(input int p, input logic v, input addr_t a);
    if (p != 0) begin s1_if.arvalid = v; s1_if.araddr = a; end
    else        begin s0_if.arvalid = v; s0_if.araddr = a; end
  endtask
  task automatic drv_rready(input int p, input logic v);
    if (p != 0) s1_if.rready = v; else s0_if.rready = v;
  endtask
  task automatic drv_aw(input int p, input logic v, input addr_t a);
    if (p != 0) begin s1_if.awvalid = v; s1_if.awaddr = a; end
    else        begin s0_if.awvalid = v; s0_if.awaddr = a; end
  endtask
  task automatic drv_w(input int p, input logic v, input data_t d);
    if (p != 0) begin s1_if.wvalid = v; s1_if.wdata = d; s1_if.wstrb = 4'hf; end
    else        begin s0_if.wvalid = v; s0_if.wdata = d; s0_if.wstrb = 4'hf; end
  endtask
  task automatic drv_bready(input int p, input logic v);
    if (p != 0) s1_if.bready = v; else s0_if.bready = v;
  endtask

  // Called at a negedge; waits (bounded) for a port response signal
  task automatic wait_sig(input int p, input int k, input string name);
    int t = 0;
    while (!sig(p, k) && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!sig(p, k)) begin
      n_assert++; n_fail++;
      $display("FAIL timeout %s port %0d: got no response, expected one within 200 cycles", name, p);
    end
  endtask

  // Tasks below are entered just after a posedge and return just after one
  task automatic do_read(input int p, input addr_t a, input int hold, input bit chk_lat,
                         output data_t d, output resp_t r);
    rd_addr[p] = a;
    drv_ar(p, 1'b1, a);
    drv_rready(p, hold == 0);
    @(negedge aclk);
    if (chk_lat) begin
      check("lat_idle_arvalid", 32'(m_if.arvalid), 32'd0);
      @(negedge aclk);
      check("lat_arvalid", 32'(m_if.arvalid), 32'd1);
      check("lat_grant", 32'(grant_o), 32'(p));
    end
    wait_sig(p, 0, "arready");
    @(posedge aclk); #1;
    drv_ar(p, 1'b0, '0);
    @(negedge aclk);
    wait_sig(p, 1, "rvalid");
    d = rdata_p(p);
    r = rresp_p(p);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge aclk);
        check("hold_rvalid", 32'(sig(p, 1)), 32'd1);
        check("hold_rdata", rdata_p(p), d);
      end
      @(posedge aclk); #1;
      drv_rready(p, 1'b1);
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    drv_rready(p, 1'b0);
  endtask

  task automatic do_write(input int p, input addr_t a, input data_t d, output resp_t r);
    wr_addr[p] = a;
    if (in_win(a)) model_mem[a[12:2]] = d;
    drv_aw(p, 1'b1, a);
    drv_w(p, 1'b1, d);
    drv_bready(p, 1'b1);
    @(negedge aclk);
    wait_sig(p, 2, "awready");
    @(posedge aclk); #1;
    drv_aw(p, 1'b0, '0);
    @(negedge aclk);
    wait_sig(p, 3, "wready");
    @(posedge aclk); #1;
    drv_w(p, 1'b0, '0);
    @(negedge aclk);
    wait_sig(p, 4, "bvalid");
    r = bresp_p(p);
    @(posedge aclk); #1;
    drv_bready(p, 1'b0);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drv_ar(p, 1'b0, '0); drv_rready(p, 1'b0);
      drv_aw(p, 1'b0, '0); drv_w(p, 1'b0, '0); drv_bready(p, 1'b0);
    end
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_m_valids", {29'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 32'd0);
    check("rst_s0_ctl", ctl_p(0), 32'd0);
    check("rst_s1_ctl", ctl_p(1), 32'd0);
    @(posedge aclk); #1;
  endtask

  // Cycle-by-cycle comparison against the transaction-level model
  initial begin
    forever begin
      @(negedge aclk);
      if (areset_n) begin
        check("nongrant_ctl", ctl_p(grant_o ? 0 : 1), 32'd0);
        check("nongrant_rdata", rdata_p(grant_o ? 0 : 1), 32'd0);
        if (m_quiet)
          check("m_quiet", {29'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 32'd0);
        if (m_if.wvalid) check("w_after_aw", 32'(have_aw), 32'd1);
        for (int p = 0; p < 2; p++) begin
          if (sig(p, 1) && rready_p(p)) begin
            check("r_grant", 32'(grant_o), 32'(p));
            check("r_data", rdata_p(p), in_win(rd_addr[p]) ? model_mem[rd_addr[p][12:2]] : 32'd0);
            check("r_resp", 32'(rresp_p(p)), in_win(rd_addr[p]) ? 32'(RESP_OKAY) : 32'(RESP_DECERR));
            glog.push_back(p);
          end
          if (sig(p, 4) && bready_p(p)) begin
            check("b_grant", 32'(grant_o), 32'(p));
            check("b_resp", 32'(bresp_p(p)), in_win(wr_addr[p]) ? 32'(RESP_OKAY) : 32'(RESP_DECERR));
            glog.push_back(p);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t d, d0, d1;
    resp_t r, r0, r1;
    int c0;
    logic [31:0] exp_order [6];

    for (int i = 0; i < 2048; i++) begin
      mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
      model_mem[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF; model_mem[4] = 32'hDEAD_BEEF;

    // Reset then single read
    do_reset();
    glog.delete();
    do_read(0, 32'h10, 0, 1'b1, d, r);
    check("t1_rdata", d, 32'hDEAD_BEEF);
    check("t1_rresp", 32'(r), 32'(RESP_OKAY));
    check("t1_log", 32'(glog.size()), 32'd1);

    // Contention: strict alternation starting with port 0 after reset
    do_reset();
    glog.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_read(0, 32'h40 + 4 * i, 0, 1'b0, d0, r0);
      end
      begin
        for (int i = 0; i < 3; i++) do_read(1, 32'h80 + 4 * i, 0, 1'b0, d1, r1);
      end
    join
    exp_order = '{0, 1, 0, 1, 0, 1};
    check("t2_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check("t2_order", 32'(glog[i]), exp_order[i]);

    // Write then readback
    glog.delete();
    do_write(1, 32'h24, 32'hCAFE_F00D, r);
    check("t3_bresp", 32'(r), 32'(RESP_OKAY));
    check("t3_mem", mem[9], 32'hCAFE_F00D);
    do_read(0, 32'h24, 0, 1'b0, d, r);
    check("t3_readback", d, 32'hCAFE_F00D);

    // Out-of-window read and write
    c0 = wr_count;
    m_quiet = 1'b1;
    do_read(1, 32'h2000, 0, 1'b0, d, r);
    check("t4_rresp", 32'(r), 32'h3);
    check("t4_rdata", d, 32'd0);
    do_write(1, 32'hFFFF_FFFC, 32'h5555_AAAA, r);
    check("t4_bresp", 32'(r), 32'h3);
    m_quiet = 1'b0;
    check("t4_no_writes", 32'(wr_count), 32'(c0));
    check("t4_mem0", mem[0], 32'h1000_0000);

    // Back-pressure on s0 while s1 has a write pending
    glog.delete();
    fork
      do_read(0, 32'h10, 5, 1'b0, d0, r0);
      begin
        repeat (2) @(posedge aclk);
        #1;
        do_write(1, 32'h50, 32'h1234_5678, r1);
      end
    join
    check("t5_data", d0, 32'hDEAD_BEEF);
    check("t5_bresp", 32'(r1), 32'(RESP_OKAY));
    check("t5_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t5_first", 32'(glog[0]), 32'd0);
      check("t5_second", 32'(glog[1]), 32'd1);
    end

    // Reset while in W
    c0 = wr_count;
    drv_aw(1, 1'b1, 32'h30);
    drv_bready(1, 1'b1);
    @(negedge aclk);
    wait_sig(1, 2, "awready");
    @(posedge aclk); #1;
    drv_aw(1, 1'b0, '0);
    @(negedge aclk);
    check("t6_busy_in_w", 32'(busy_o), 32'd1);
    @(posedge aclk); #1;
    areset_n = 1'b0;
    @(posedge aclk); #1;
    check("t6_busy_after_rst", 32'(busy_o), 32'd0);
    check("t6_m_valids", {29'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 32'd0);
    check("t6_s1_ctl", ctl_p(1), 32'd0);
    areset_n = 1'b1;
    drv_bready(1, 1'b0);
    @(posedge aclk); #1;
    do_read(0, 32'h10, 0, 1'b0, d, r);
    check("t6_read", d, 32'hDEAD_BEEF);
    check("t6_no_write", 32'(wr_count), 32'(c0));

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
